alu_issue_queue: RTL and testbench

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

---
 rtl/alu_issue_queue_pkg.sv | 25 ++
 rtl/alu_req_fifo.sv | 53 +++++
 rtl/alu_issue_queue.sv | 142 ++++++++++++++
 tb/tb_alu_issue_queue.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_queue_pkg.sv
// Shared types and defaults for the ALU issue queue: FSM state encoding,
// response flag bit positions and default widths/latency.
package alu_issue_queue_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_CMD_WIDTH  = 4;
  localparam int unsigned DEF_ALU_LAT    = 3;
  localparam int unsigned ID_WIDTH       = 8;
  localparam int unsigned FLAG_WIDTH     = 6;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_RESP  = 2'd3;

  // rsp_flags layout {cout,g,l,e,oflow,err}
  localparam int unsigned FLAG_ERR   = 0;
  localparam int unsigned FLAG_OFLOW = 1;
  localparam int unsigned FLAG_E     = 2;
  localparam int unsigned FLAG_L     = 3;
  localparam int unsigned FLAG_G     = 4;
  localparam int unsigned FLAG_COUT  = 5;

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO for the ALU issue queue; DEPTH must be a power of two so the
// pointers wrap naturally modulo DEPTH.
module alu_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Queues ALU requests and issues them one at a time to an external ALU,
// returning responses in order. Optional error counter: ALU_ISSUE_ERR_CNT_EN.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CMD_WIDTH  = DEF_CMD_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ALU_LAT    = DEF_ALU_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [7:0]              req_id,
  input  logic                    req_mode,
  input  logic [CMD_WIDTH-1:0]    req_cmd,
  input  logic [1:0]              req_inp_valid,
  input  logic                    req_cin,
  input  logic [DATA_WIDTH-1:0]   req_opa,
  input  logic [DATA_WIDTH-1:0]   req_opb,
  output logic                    alu_ce,
  output logic                    alu_mode,
  output logic [1:0]              alu_inp_valid,
  output logic [CMD_WIDTH-1:0]    alu_cmd,
  output logic                    alu_cin,
  output logic [DATA_WIDTH-1:0]   alu_opa,
  output logic [DATA_WIDTH-1:0]   alu_opb,
  input  logic [2*DATA_WIDTH:0]   alu_res,
  input  logic                    alu_cout,
  input  logic                    alu_g,
  input  logic                    alu_l,
  input  logic                    alu_e,
  input  logic                    alu_oflow,
  input  logic                    alu_err,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [7:0]              rsp_id,
  output logic [2*DATA_WIDTH:0]   rsp_res,
  output logic [5:0]              rsp_flags
`ifdef ALU_ISSUE_ERR_CNT_EN
  ,
  output logic [15:0]             err_count
`endif
);

  localparam int unsigned ENTRY_W = ID_WIDTH + 1 + CMD_WIDTH + 2 + 1 + 2*DATA_WIDTH;
  localparam int unsigned LAT_W   = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t               state;
  logic [LAT_W-1:0]     lat_cnt;
  logic [ID_WIDTH-1:0]  op_id;
  logic [ENTRY_W-1:0]   wr_entry;
  logic [ENTRY_W-1:0]   head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  // Held low during reset so every output reads 0 while rst is asserted.
  assign req_ready = !fifo_full && !rst;
  assign push      = req_valid && req_ready;
  assign pop       = (state == S_IDLE) && !fifo_empty;
  assign wr_entry  = {req_id, req_mode, req_cmd, req_inp_valid, req_cin, req_opa, req_opb};

  alu_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign alu_ce    = (state == S_ISSUE) || (state == S_WAIT);
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      lat_cnt       <= '0;
      op_id         <= '0;
      alu_mode      <= 1'b0;
      alu_cmd       <= '0;
      alu_inp_valid <= '0;
      alu_cin       <= 1'b0;
      alu_opa       <= '0;
      alu_opb       <= '0;
      rsp_id        <= '0;
      rsp_res       <= '0;
      rsp_flags     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            {op_id, alu_mode, alu_cmd, alu_inp_valid, alu_cin, alu_opa, alu_opb} <= head;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          lat_cnt <= LAT_W'(ALU_LAT - 1);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            rsp_id                <= op_id;
            rsp_res               <= alu_res;
            rsp_flags[FLAG_COUT]  <= alu_cout;
            rsp_flags[FLAG_G]     <= alu_g;
            rsp_flags[FLAG_L]     <= alu_l;
            rsp_flags[FLAG_E]     <= alu_e;
            rsp_flags[FLAG_OFLOW] <= alu_oflow;
            rsp_flags[FLAG_ERR]   <= alu_err;
            state                 <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (rsp_valid && rsp_ready && rsp_flags[FLAG_ERR] && (err_count != '1)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue with a behavioural ALU model;
// build with ALU_ISSUE_ERR_CNT_EN to also cover the error counter.
module tb_alu_issue_queue;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned RW = 2*DW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_id;
  logic          req_mode;
  logic [CW-1:0] req_cmd;
  logic [1:0]    req_inp_valid;
  logic          req_cin;
  logic [DW-1:0] req_opa;
  logic [DW-1:0] req_opb;
  logic          alu_ce;
  logic          alu_mode;
  logic [1:0]    alu_inp_valid;
  logic [CW-1:0] alu_cmd;
  logic          alu_cin;
  logic [DW-1:0] alu_opa;
  logic [DW-1:0] alu_opb;
  logic [RW-1:0] alu_res;
  logic          alu_cout, alu_g, alu_l, alu_e, alu_oflow, alu_err;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [7:0]    rsp_id;
  logic [RW-1:0] rsp_res;
  logic [5:0]    rsp_flags;
`ifdef ALU_ISSUE_ERR_CNT_EN
  logic [15:0]   err_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]    id;
    logic [RW-1:0] res;
    logic [5:0]    flags;
  } exp_t;
  exp_t sb[$];

  logic [57:0] all_outs;
  assign all_outs = {rsp_valid, rsp_id, rsp_res, rsp_flags, alu_ce, alu_mode, alu_inp_valid,
                     alu_cmd, alu_cin, alu_opa, alu_opb, req_ready};

  // Behavioural ALU: outputs only meaningful while alu_ce is high.
  logic [DW:0] sum;
  always_comb begin
    sum       = {1'b0, alu_opa} + {1'b0, alu_opb} + {{DW{1'b0}}, alu_cin};
    alu_res   = '0;
    alu_cout  = 1'b0;
    alu_g     = 1'b0;
    alu_l     = 1'b0;
    alu_e     = 1'b0;
    alu_oflow = 1'b0;
    alu_err   = 1'b0;
    if (alu_ce === 1'b1) begin
      if (alu_inp_valid == 2'b00) begin
        alu_err = 1'b1;
      end else if (alu_mode) begin
        if (alu_cmd == 4'd0) begin
          alu_res   = {{DW{1'b0}}, sum};
          alu_cout  = sum[DW];
          alu_oflow = (alu_opa[DW-1] == alu_opb[DW-1]) && (sum[DW-1] != alu_opa[DW-1]);
        end else if (alu_cmd == 4'd8) begin
          alu_g = alu_opa > alu_opb;
          alu_l = alu_opa < alu_opb;
          alu_e = alu_opa == alu_opb;
        end else begin
          alu_err = 1'b1;
        end
      end else begin
        case (alu_cmd)
          4'd0:    alu_res = {{(DW+1){1'b0}}, alu_opa & alu_opb};
          4'd1:    alu_res = {{(DW+1){1'b0}}, alu_opa | alu_opb};
          4'd2:    alu_res = {{(DW+1){1'b0}}, alu_opa ^ alu_opb};
          default: alu_err = 1'b1;
        endcase
      end
    end
  end

  alu_issue_queue #(
    .DATA_WIDTH (DW),
    .CMD_WIDTH  (CW),
    .DEPTH      (4),
    .ALU_LAT    (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_id        (req_id),
    .req_mode      (req_mode),
    .req_cmd       (req_cmd),
    .req_inp_valid (req_inp_valid),
    .req_cin       (req_cin),
    .req_opa       (req_opa),
    .req_opb       (req_opb),
    .alu_ce        (alu_ce),
    .alu_mode      (alu_mode),
    .alu_inp_valid (alu_inp_valid),
    .alu_cmd       (alu_cmd),
    .alu_cin       (alu_cin),
    .alu_opa       (alu_opa),
    .alu_opb       (alu_opb),
    .alu_res       (alu_res),
    .alu_cout      (alu_cout),
    .alu_g         (alu_g),
    .alu_l         (alu_l),
    .alu_e         (alu_e),
    .alu_oflow     (alu_oflow),
    .alu_err       (alu_err),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_res       (rsp_res),
    .rsp_flags     (rsp_flags)
`ifdef ALU_ISSUE_ERR_CNT_EN
    ,
    .err_count     (err_count)
`endif
  );

  // Offers one request (caller sits at a negedge); pushes its expectation when accepted.
  task automatic offer(input logic [7:0] id, input logic mode, input logic [CW-1:0] cmd,
                       input logic [1:0] iv, input logic cin, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [RW-1:0] eres,
                       input logic [5:0] eflags, output bit acc);
    exp_t e;
    int   n;
    req_valid = 1'b1; req_id = id; req_mode = mode; req_cmd = cmd;
    req_inp_valid = iv; req_cin = cin; req_opa = a; req_opb = b;
    n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    acc = (req_ready === 1'b1);
    if (acc) begin
      e.id = id; e.res = eres; e.flags = eflags;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_id = '0; req_mode = 1'b0;
    req_cmd = '0; req_inp_valid = '0; req_cin = 1'b0; req_opa = '0; req_opb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
`ifdef ALU_ISSUE_ERR_CNT_EN
    checks++;
    if (err_count !== 16'd0) begin
      errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_rsp_valid: got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_add_latency();
    exp_t e;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_id = 8'h10; req_mode = 1'b1; req_cmd = 4'd0;
    req_inp_valid = 2'b11; req_cin = 1'b0; req_opa = 8'd10; req_opb = 8'd20;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL add_accept: req_ready got %b expected 1", req_ready);
    end
    e.id = 8'h10; e.res = 17'd30; e.flags = 6'b000000;
    sb.push_back(e);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 0) req_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'(c == 5)) begin
        errors++; $display("FAIL add_latency cycle %0d: rsp_valid got %b expected %b", c, rsp_valid, (c == 5));
      end
      checks++;
      if (alu_ce !== 1'(c >= 1 && c <= 4)) begin
        errors++; $display("FAIL add_alu_ce cycle %0d: got %b expected %b", c, alu_ce, (c >= 1 && c <= 4));
      end
    end
    e = sb.pop_front();
    checks++;
    if ({rsp_id, rsp_res, rsp_flags} !== {e.id, e.res, e.flags}) begin
      errors++;
      $display("FAIL add_rsp: got id=%h res=%0d flags=%b expected id=%h res=%0d flags=%b",
               rsp_id, rsp_res, rsp_flags, e.id, e.res, e.flags);
    end
    checks++;
    if ({alu_opa, alu_opb} !== {8'd10, 8'd20}) begin
      errors++; $display("FAIL add_operands_stable: got %0d,%0d expected 10,20", alu_opa, alu_opb);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL add_handshake: rsp_valid got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_logical();
    exp_t e;
    bit   acc;
    bit   acc_all;
    int   n;
    rsp_ready = 1'b0;
    acc_all = 1'b1;
    offer(8'h20, 1'b0, 4'd0, 2'b11, 1'b0, 8'hF0, 8'h3C, 17'h30,  6'b000000, acc); acc_all &= acc;
    offer(8'h21, 1'b0, 4'd1, 2'b11, 1'b0, 8'hA0, 8'h05, 17'hA5,  6'b000000, acc); acc_all &= acc;
    offer(8'h22, 1'b0, 4'd2, 2'b11, 1'b0, 8'hFF, 8'h0F, 17'hF0,  6'b000000, acc); acc_all &= acc;
    offer(8'h23, 1'b1, 4'd0, 2'b11, 1'b1, 8'd200, 8'd100, 17'd301, 6'b100000, acc); acc_all &= acc;
    offer(8'h24, 1'b1, 4'd0, 2'b11, 1'b0, 8'h70, 8'h20, 17'h90,  6'b000010, acc); acc_all &= acc;
    checks++;
    if (acc_all !== 1'b1) begin
      errors++; $display("FAIL logical_accept: all accepted got %b expected 1", acc_all);
    end
    rsp_ready = 1'b1;
    while (sb.size() > 0) begin
      n = 0;
      while (rsp_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== 1'b1) begin
        errors++; $display("FAIL logical_timeout: id %h rsp_valid got %b expected 1", e.id, rsp_valid);
        sb.delete();
      end else begin
        if ({rsp_id, rsp_res, rsp_flags} !== {e.id, e.res, e.flags}) begin
          errors++;
          $display("FAIL logical_rsp: got id=%h res=%h flags=%b expected id=%h res=%h flags=%b",
                   rsp_id, rsp_res, rsp_flags, e.id, e.res, e.flags);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    bit   acc;
    int   n;
    rsp_ready = 1'b0;
    offer(8'h30, 1'b0, 4'd2, 2'b11, 1'b0, 8'h5A, 8'h0F, 17'h55, 6'b000000, acc);
    checks++;
    if (acc !== 1'b1) begin
      errors++; $display("FAIL hold_accept: got %b expected 1", acc);
    end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    e = sb.pop_front();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_res, rsp_flags} !== {1'b1, e.id, e.res, e.flags}) begin
        errors++;
        $display("FAIL hold_cycle %0d: got valid=%b id=%h res=%h flags=%b expected valid=1 id=%h res=%h flags=%b",
                 c, rsp_valid, rsp_id, rsp_res, rsp_flags, e.id, e.res, e.flags);
      end
      if (c == 9) rsp_ready = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release: rsp_valid got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n;
    bit   seen;
    rsp_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      req_valid = 1'b1; req_id = 8'(i); req_mode = 1'b1; req_cmd = 4'd0;
      req_inp_valid = 2'b11; req_cin = 1'b0; req_opa = 8'(i); req_opb = 8'(i * 16);
      checks++;
      if (req_ready !== 1'(i <= 5)) begin
        errors++; $display("FAIL b2b_ready id %0d: got %b expected %b", i, req_ready, (i <= 5));
      end
      if (i <= 5) begin
        e.id = 8'(i); e.res = RW'(17 * i); e.flags = 6'b000000;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while (sb.size() > 0) begin
      n = 0;
      while (rsp_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_timeout: id %h rsp_valid got %b expected 1", e.id, rsp_valid);
        sb.delete();
      end else begin
        if ({rsp_id, rsp_res, rsp_flags} !== {e.id, e.res, e.flags}) begin
          errors++;
          $display("FAIL b2b_rsp: got id=%h res=%0d flags=%b expected id=%h res=%0d flags=%b",
                   rsp_id, rsp_res, rsp_flags, e.id, e.res, e.flags);
        end
        @(negedge clk);
      end
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL b2b_extra_rsp: unexpected response got id=%h expected none", rsp_id);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   acc;
    bit   seen;
    int   n;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_id = 8'h31; req_mode = 1'b1; req_cmd = 4'd0;
    req_inp_valid = 2'b11; req_cin = 1'b0; req_opa = 8'd3; req_opb = 8'd4;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_accept: got %b expected 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({alu_ce, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL rstmid_in_wait: alu_ce,rsp_valid got %b expected 10", {alu_ce, rsp_valid});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got %h expected 0", all_outs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready: got %b expected 1", req_ready);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rstmid_dropped: response for dropped op got %b expected 0", seen);
    end
    rsp_ready = 1'b0;
    offer(8'h32, 1'b1, 4'd0, 2'b11, 1'b0, 8'd1, 8'd1, 17'd2, 6'b000000, acc);
    rsp_ready = 1'b1;
    while (sb.size() > 0) begin
      n = 0;
      while (rsp_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== 1'b1) begin
        errors++; $display("FAIL rstmid_timeout: id %h rsp_valid got %b expected 1", e.id, rsp_valid);
        sb.delete();
      end else begin
        if ({rsp_id, rsp_res, rsp_flags} !== {e.id, e.res, e.flags}) begin
          errors++;
          $display("FAIL rstmid_rsp: got id=%h res=%0d flags=%b expected id=%h res=%0d flags=%b",
                   rsp_id, rsp_res, rsp_flags, e.id, e.res, e.flags);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_flags();
    exp_t e;
    bit   acc;
    bit   acc_all;
    int   n;
    rsp_ready = 1'b0;
    acc_all = 1'b1;
    offer(8'h40, 1'b1, 4'd0, 2'b00, 1'b0, 8'd7, 8'd9, 17'd0, 6'b000001, acc); acc_all &= acc;
    offer(8'h41, 1'b1, 4'd8, 2'b11, 1'b0, 8'd5, 8'd5, 17'd0, 6'b000100, acc); acc_all &= acc;
    checks++;
    if (acc_all !== 1'b1) begin
      errors++; $display("FAIL flags_accept: got %b expected 1", acc_all);
    end
    rsp_ready = 1'b1;
    while (sb.size() > 0) begin
      n = 0;
      while (rsp_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== 1'b1) begin
        errors++; $display("FAIL flags_timeout: id %h rsp_valid got %b expected 1", e.id, rsp_valid);
        sb.delete();
      end else begin
        if ({rsp_id, rsp_res, rsp_flags} !== {e.id, e.res, e.flags}) begin
          errors++;
          $display("FAIL flags_rsp: got id=%h res=%0d flags=%b expected id=%h res=%0d flags=%b",
                   rsp_id, rsp_res, rsp_flags, e.id, e.res, e.flags);
        end
        @(negedge clk);
      end
    end
`ifdef ALU_ISSUE_ERR_CNT_EN
    checks++;
    if (err_count !== 16'd1) begin
      errors++; $display("FAIL err_count: got %0d expected 1", err_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_logical();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_flags();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
